// File: rtl/k007232_pkg.sv
// Shared definitions for the 007232 sample-ROM fetch path.
// Channel encodings, sample-address width and the fetch FSM state type.
package k007232_pkg;
  localparam int   SA_W = 17;
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic {IDLE, WAIT} fetch_state_t;
endpackage

// File: rtl/k007232_fetch_slot.sv
// One per-channel cache slot: wanted address, fetched tag/data and a pending flag.
// Pending is raised only once the chip has presented an address since reset.
module k007232_fetch_slot
  import k007232_pkg::*;
(
  input  logic            mclk,
  input  logic            i_RST,
  input  logic            cap_en,
  input  logic [SA_W-1:0] cap_addr,
  input  logic            wr_en,
  input  logic [SA_W-1:0] wr_tag,
  input  logic [7:0]      wr_data,
  output logic [SA_W-1:0] want,
  output logic [7:0]      data,
  output logic            pending
);
  logic [SA_W-1:0] want_reg;
  logic [SA_W-1:0] tag_reg;
  logic [7:0]      data_reg;
  logic            valid_reg;
  logic            armed_reg;

  always_ff @(posedge mclk) begin
    if (i_RST) begin
      want_reg  <= '0;
      tag_reg   <= '0;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      if (cap_en) begin
        want_reg  <= cap_addr;
        armed_reg <= 1'b1;
      end
      if (wr_en) begin
        tag_reg   <= wr_tag;
        data_reg  <= wr_data;
        valid_reg <= 1'b1;
      end
    end
  end

  // A fetch that returns for an address the chip has since left still lands,
  // and the mismatch keeps the slot pending so it is refetched.
  assign pending = armed_reg && (!valid_reg || (want_reg != tag_reg));
  assign want    = want_reg;
  assign data    = data_reg;
endmodule

// File: rtl/k007232_rom_fetch_arbiter.sv
// Shares one req/ack byte memory port between the two 007232 PCM channels:
// round-robin refill of per-channel slots, phase-muxed data out, late-phase flags.
module k007232_rom_fetch_arbiter
  import k007232_pkg::*;
#(
  parameter int                ROM_AW   = 25,
  parameter logic [ROM_AW-1:0] ROM_BASE = '0
) (
  input  logic              mclk,
  input  logic              i_RST,
  input  logic              i_PCEN,
  input  logic [SA_W-1:0]   i_SA,
  input  logic              i_CH_SEL,
  output logic [7:0]        o_RAM,
  output logic              o_MEM_REQ,
  output logic [ROM_AW-1:0] o_MEM_ADDR,
  input  logic              i_MEM_ACK,
  input  logic [7:0]        i_MEM_DATA,
  output logic [1:0]        o_LATE
);
  logic [1:0]      cap_en;
  logic [1:0]      wr_en;
  logic [1:0]      pending;
  logic [1:0]      late_next;
  logic [SA_W-1:0] want [2];
  logic [7:0]      data [2];

  fetch_state_t      state_reg, state_next;
  logic              req_reg, req_next;
  logic [ROM_AW-1:0] addr_reg, addr_next;
  logic [SA_W-1:0]   tag_reg, tag_next;
  logic              ch_reg, ch_next;
  logic              prio_reg, prio_next;
  logic              sel_prev_reg;
  logic [1:0]        late_reg;
  logic              pick_ch;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign cap_en[gi]    = i_PCEN && (i_CH_SEL == 1'(gi));
      assign wr_en[gi]     = (state_reg == WAIT) && i_MEM_ACK && (ch_reg == 1'(gi));
      // Phase for this channel is ending while its slot is still stale.
      assign late_next[gi] = i_PCEN && (sel_prev_reg == 1'(gi)) &&
                             (i_CH_SEL != 1'(gi)) && pending[gi];

      k007232_fetch_slot u_slot (
        .mclk    (mclk),
        .i_RST   (i_RST),
        .cap_en  (cap_en[gi]),
        .cap_addr(i_SA),
        .wr_en   (wr_en[gi]),
        .wr_tag  (tag_reg),
        .wr_data (i_MEM_DATA),
        .want    (want[gi]),
        .data    (data[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  always_ff @(posedge mclk) begin
    if (i_RST) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
      tag_reg      <= '0;
      ch_reg       <= CH_A;
      prio_reg     <= CH_A;
      sel_prev_reg <= CH_A;
      late_reg     <= 2'b00;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      tag_reg   <= tag_next;
      ch_reg    <= ch_next;
      prio_reg  <= prio_next;
      late_reg  <= late_next;
      if (i_PCEN) sel_prev_reg <= i_CH_SEL;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    tag_next   = tag_reg;
    ch_next    = ch_reg;
    prio_next  = prio_reg;
    pick_ch    = CH_A;
    case (state_reg)
      IDLE: begin
        if (|pending) begin
          // prio_reg holds the channel not served last
          pick_ch    = (&pending) ? prio_reg : (pending[CH_B] ? CH_B : CH_A);
          ch_next    = pick_ch;
          tag_next   = want[pick_ch];
          addr_next  = ROM_BASE + ROM_AW'(want[pick_ch]);
          req_next   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_MEM_ACK) begin
          req_next   = 1'b0;
          prio_next  = ~ch_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_RAM      = i_CH_SEL ? data[CH_B] : data[CH_A];
  assign o_MEM_REQ  = req_reg;
  assign o_MEM_ADDR = addr_reg;
  assign o_LATE     = late_reg;
endmodule

// File: tb/tb_k007232_rom_fetch_arbiter.sv
// Directed bench for the 007232 fetch arbiter: reset, fills, round-robin,
// moved address, late flag and reset during an outstanding request.
module tb_k007232_rom_fetch_arbiter;
  localparam int            ROM_AW   = 25;
  localparam logic [24:0]   ROM_BASE = 25'h100000;

  logic              mclk = 1'b0;
  logic              i_RST = 1'b1;
  logic              i_PCEN = 1'b0;
  logic [16:0]       i_SA = '0;
  logic              i_CH_SEL = 1'b0;
  logic [7:0]        o_RAM;
  logic              o_MEM_REQ;
  logic [ROM_AW-1:0] o_MEM_ADDR;
  logic              i_MEM_ACK = 1'b0;
  logic [7:0]        i_MEM_DATA = '0;
  logic [1:0]        o_LATE;

  int total = 0;
  int bad   = 0;

  k007232_rom_fetch_arbiter #(.ROM_AW(ROM_AW), .ROM_BASE(ROM_BASE)) dut (
    .mclk      (mclk),
    .i_RST     (i_RST),
    .i_PCEN    (i_PCEN),
    .i_SA      (i_SA),
    .i_CH_SEL  (i_CH_SEL),
    .o_RAM     (o_RAM),
    .o_MEM_REQ (o_MEM_REQ),
    .o_MEM_ADDR(o_MEM_ADDR),
    .i_MEM_ACK (i_MEM_ACK),
    .i_MEM_DATA(i_MEM_DATA),
    .o_LATE    (o_LATE)
  );

  always #5 mclk = ~mclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One chip clock-enable with the given channel phase and address.
  task automatic cap(input logic ch, input logic [16:0] a);
    i_CH_SEL = ch;
    i_SA     = a;
    i_PCEN   = 1'b1;
    step();
    i_PCEN   = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    i_MEM_ACK  = 1'b1;
    i_MEM_DATA = d;
    step();
    i_MEM_ACK  = 1'b0;
  endtask

  task automatic check_ram(input string tag, input logic ch, input logic [7:0] exp);
    i_CH_SEL = ch;
    #1;
    check_val(tag, 32'(o_RAM), 32'(exp));
  endtask

  initial begin
    // 1: reset
    idle(4);
    check_val("rst_req", 32'(o_MEM_REQ), 32'd0);
    check_val("rst_addr", 32'(o_MEM_ADDR), 32'd0);
    check_val("rst_late", 32'(o_LATE), 32'd0);
    check_ram("rst_ram_a", 1'b0, 8'h00);
    i_RST = 1'b0;
    idle(3);
    check_val("no_req_before_pcen", 32'(o_MEM_REQ), 32'd0);

    // 2: single fill
    cap(1'b0, 17'h00123);
    step();
    check_val("fill_req", 32'(o_MEM_REQ), 32'd1);
    check_val("fill_addr", 32'(o_MEM_ADDR), 32'h100123);
    ack(8'h5A);
    check_val("fill_req_drop", 32'(o_MEM_REQ), 32'd0);
    check_ram("fill_ram_a", 1'b0, 8'h5A);
    check_ram("fill_ram_b_empty", 1'b1, 8'h00);
    idle(3);
    check_val("fill_no_refetch", 32'(o_MEM_REQ), 32'd0);

    // 3: round-robin
    i_RST = 1'b1; idle(2); i_RST = 1'b0;
    cap(1'b0, 17'h10);
    cap(1'b1, 17'h20);
    check_val("rr1_addr_a", 32'(o_MEM_ADDR), 32'h100010);
    ack(8'hA1);
    check_val("rr1_idle_gap", 32'(o_MEM_REQ), 32'd0);
    step();
    check_val("rr1_req_b", 32'(o_MEM_REQ), 32'd1);
    check_val("rr1_addr_b", 32'(o_MEM_ADDR), 32'h100020);
    ack(8'hB2);
    check_ram("rr1_ram_a", 1'b0, 8'hA1);
    check_ram("rr1_ram_b", 1'b1, 8'hB2);
    cap(1'b0, 17'h30);
    cap(1'b1, 17'h40);
    cap(1'b0, 17'h31);
    check_val("rr2_addr_a", 32'(o_MEM_ADDR), 32'h100030);
    ack(8'hA3);
    step();
    check_val("rr2_b_first", 32'(o_MEM_ADDR), 32'h100040);
    ack(8'hB4);
    step();
    check_val("rr2_a_refetch", 32'(o_MEM_ADDR), 32'h100031);
    ack(8'hA5);
    check_ram("rr2_ram_a", 1'b0, 8'hA5);
    check_ram("rr2_ram_b", 1'b1, 8'hB4);

    // 4: address moves while in flight
    cap(1'b0, 17'h50);
    step();
    check_val("mv_addr0", 32'(o_MEM_ADDR), 32'h100050);
    cap(1'b0, 17'h51);
    idle(2);
    check_val("mv_addr_stable", 32'(o_MEM_ADDR), 32'h100050);
    check_val("mv_req_held", 32'(o_MEM_REQ), 32'd1);
    ack(8'hC0);
    check_val("mv_req_drop", 32'(o_MEM_REQ), 32'd0);
    check_ram("mv_ram_old_tag", 1'b0, 8'hC0);
    step();
    check_val("mv_req2", 32'(o_MEM_REQ), 32'd1);
    check_val("mv_addr2", 32'(o_MEM_ADDR), 32'h100051);
    ack(8'hC1);

    // 5: late phase end with a slow ack
    cap(1'b0, 17'h60);
    idle(5);
    check_ram("late_stale_ram", 1'b0, 8'hC1);
    check_val("late_before", 32'(o_LATE), 32'd0);
    cap(1'b1, 17'h40);
    check_val("late_pulse", 32'(o_LATE), 32'b01);
    step();
    check_val("late_one_cycle", 32'(o_LATE), 32'd0);
    idle(30);
    check_ram("late_still_stale", 1'b0, 8'hC1);
    ack(8'h6D);
    check_ram("late_filled", 1'b0, 8'h6D);
    cap(1'b0, 17'h60);
    check_val("late_none_b", 32'(o_LATE), 32'd0);
    check_val("late_no_req", 32'(o_MEM_REQ), 32'd0);

    // 6: address wrap boundary, then reset mid-WAIT and a stray ack
    cap(1'b0, 17'h1FFFF);
    step();
    check_val("top_addr", 32'(o_MEM_ADDR), 32'h11FFFF);
    i_RST = 1'b1; step(); i_RST = 1'b0;
    check_val("rstw_req", 32'(o_MEM_REQ), 32'd0);
    check_val("rstw_addr", 32'(o_MEM_ADDR), 32'd0);
    ack(8'hEE);
    check_val("stray_req", 32'(o_MEM_REQ), 32'd0);
    check_ram("stray_ram_a", 1'b0, 8'h00);
    check_ram("stray_ram_b", 1'b1, 8'h00);
    idle(3);
    check_val("stray_no_req", 32'(o_MEM_REQ), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
